urv_pipe_ctrl: RTL and testbench

URV_PIPE_CTRL -- requirements
Module: urv_pipe_ctrl

---
 rtl/urv_pipe_ctrl_pkg.sv | 21 ++
 rtl/urv_pipe_ctrl_if.sv | 30 +++
 rtl/urv_sat_counter.sv | 27 ++
 rtl/urv_pipe_ctrl.sv | 105 ++++++++++
 tb/tb_urv_pipe_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/urv_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: debug FSM encoding and legal
// configuration ranges.
package urv_defs;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } dbg_state_e;

    localparam int MIN_STAGES       = 3;
    localparam int MAX_STAGES       = 8;
    localparam int MIN_BRANCH_STAGE = 1;

    // Branch stage must leave at least one stage behind it for writeback.
    function automatic bit cfg_legal(input int n, input int b);
        return (n >= MIN_STAGES) && (n <= MAX_STAGES) &&
               (b >= MIN_BRANCH_STAGE) && (b <= n - 2);
    endfunction

endpackage

// File: rtl/urv_pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and the controller (slave).
interface urv_pipe_ctrl_if #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 32
);
    logic [NUM_STAGES-1:0] stall_req_i;
    logic [NUM_STAGES-1:0] stage_valid_i;
    logic                  branch_i;
    logic                  trap_i;
    logic                  dbg_halt_req_i;
    logic                  dbg_resume_req_i;
    logic                  stall_cnt_clr_i;
    logic [NUM_STAGES-1:0] stall_o;
    logic [NUM_STAGES-1:0] kill_o;
    logic                  dbg_halted_o;
    logic                  flush_active_o;
    logic [CNT_W-1:0]      stall_cnt_o;

    modport master (
        output stall_req_i, stage_valid_i, branch_i, trap_i,
               dbg_halt_req_i, dbg_resume_req_i, stall_cnt_clr_i,
        input  stall_o, kill_o, dbg_halted_o, flush_active_o, stall_cnt_o
    );

    modport slave (
        input  stall_req_i, stage_valid_i, branch_i, trap_i,
               dbg_halt_req_i, dbg_resume_req_i, stall_cnt_clr_i,
        output stall_o, kill_o, dbg_halted_o, flush_active_o, stall_cnt_o
    );
endinterface

// File: rtl/urv_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module urv_sat_counter #(
    parameter int g_width = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [g_width-1:0] cnt_o
);
    logic [g_width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != {g_width{1'b1}}))
            cnt_d = cnt_q + g_width'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/urv_pipe_ctrl.sv
// Pipeline stall/kill controller with redirect flush tracking, optional debug
// halt FSM and a saturating stall-cycle counter.
module urv_pipe_ctrl
    import urv_defs::*;
#(
    parameter int g_num_stages      = 4,
    parameter int g_branch_stage    = 2,
    parameter int g_with_debug      = 0,
    parameter int g_stall_cnt_width = 32
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    urv_pipe_ctrl_if.slave bus
);
    localparam int N = g_num_stages;
    localparam int B = g_branch_stage;

    logic         redirect;
    logic [N-1:0] stall, kill;
    logic [B-1:0] fsr_q, fsr_d, fsr_shift;
    logic         flush_active;
    logic         in_drain, in_halted;
    dbg_state_e   state_q, state_d;
    logic         dbg_halted_q, dbg_halted_d;
    logic         unused_valid_lo;

    assign redirect     = bus.branch_i | bus.trap_i;
    assign flush_active = redirect | (|fsr_q);
    assign in_drain     = (state_q == ST_DRAIN);
    assign in_halted    = (state_q == ST_HALTED);

    // A stall anywhere downstream backs up every earlier stage; writeback never stalls.
    for (genvar k = 0; k < N - 1; k++) begin : g_stall
        assign stall[k] = (|bus.stall_req_i[N-1:k])
                        | ((k <  B) && in_drain)
                        | ((k <= B) && in_halted);
    end
    assign stall[N-1] = 1'b0;

    // Stage k is killed while the redirect, or any flush bit that has not yet
    // travelled past it, is alive.
    for (genvar k = 0; k < N; k++) begin : g_kill
        if (k == 0) begin : g_k0
            assign kill[k] = redirect;
        end else if (k <= B) begin : g_kmid
            assign kill[k] = redirect | (|fsr_q[k-1:0]);
        end else begin : g_kpost
            assign kill[k] = 1'b0;
        end
    end

    if (B == 1) begin : g_shift1
        assign fsr_shift = redirect;
    end else begin : g_shiftn
        assign fsr_shift = {fsr_q[B-2:0], redirect};
    end

    // The flush window advances only when the branch stage moves, so a held
    // redirect never double-counts and a stalled one is never lost.
    always_comb begin
        fsr_d = fsr_q;
        if (!stall[B]) fsr_d = fsr_shift;
    end

    always_comb begin
        state_d = ST_RUN;
        if (g_with_debug != 0) begin
            state_d = state_q;
            case (state_q)
                ST_RUN:    if (bus.dbg_halt_req_i) state_d = ST_DRAIN;
                ST_DRAIN:  if (!(|bus.stage_valid_i[N-1:B]) && !flush_active)
                               state_d = ST_HALTED;
                ST_HALTED: if (bus.dbg_resume_req_i) state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end
        dbg_halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fsr_q        <= '0;
            state_q      <= ST_RUN;
            dbg_halted_q <= 1'b0;
        end else begin
            fsr_q        <= fsr_d;
            state_q      <= state_d;
            dbg_halted_q <= dbg_halted_d;
        end
    end

    urv_sat_counter #(.g_width(g_stall_cnt_width)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (bus.stall_cnt_clr_i),
        .inc_i   (stall[0]),
        .cnt_o   (bus.stall_cnt_o)
    );

    assign unused_valid_lo    = ^bus.stage_valid_i[B-1:0];
    assign bus.stall_o        = stall;
    assign bus.kill_o         = kill;
    assign bus.flush_active_o = flush_active;
    assign bus.dbg_halted_o   = dbg_halted_q;
endmodule

// File: tb/tb_urv_pipe_ctrl.sv
// Scoreboard bench: debug-enabled 4-bit-counter instance plus a default instance.
module tb_urv_pipe_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    urv_pipe_ctrl_if #(.NUM_STAGES(4), .CNT_W(4))  ifa ();
    urv_pipe_ctrl_if #(.NUM_STAGES(4), .CNT_W(32)) ifb ();

    assign ifb.stall_req_i      = ifa.stall_req_i;
    assign ifb.stage_valid_i    = ifa.stage_valid_i;
    assign ifb.branch_i         = ifa.branch_i;
    assign ifb.trap_i           = ifa.trap_i;
    assign ifb.dbg_halt_req_i   = ifa.dbg_halt_req_i;
    assign ifb.dbg_resume_req_i = ifa.dbg_resume_req_i;
    assign ifb.stall_cnt_clr_i  = ifa.stall_cnt_clr_i;

    urv_pipe_ctrl #(.g_num_stages(4), .g_branch_stage(2), .g_with_debug(1),
                    .g_stall_cnt_width(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(ifa));

    urv_pipe_ctrl #(.g_num_stages(4), .g_branch_stage(2), .g_with_debug(0),
                    .g_stall_cnt_width(32)) dut_nd (
        .clk_i(clk), .rst_n_i(rst_n), .bus(ifb));

    typedef struct packed {
        logic [3:0] stall;
        logic [3:0] kill;
        logic       flush;
        logic       halted;
    } obs_t;

    obs_t        sb[$];
    logic [31:0] cq[$];

    function automatic obs_t mk(input logic [3:0] s, input logic [3:0] k,
                                input logic f, input logic h);
        obs_t o;
        o.stall = s; o.kill = k; o.flush = f; o.halted = h;
        return o;
    endfunction

    function automatic obs_t sample_a();
        return mk(ifa.stall_o, ifa.kill_o, ifa.flush_active_o, ifa.dbg_halted_o);
    endfunction

    task automatic drive(input logic [3:0] req, input logic [3:0] vld, input logic br,
                         input logic tr, input logic hr, input logic rs, input logic clr);
        ifa.stall_req_i = req;  ifa.stage_valid_i = vld;
        ifa.branch_i = br;      ifa.trap_i = tr;
        ifa.dbg_halt_req_i = hr; ifa.dbg_resume_req_i = rs;
        ifa.stall_cnt_clr_i = clr;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        obs_t o, e;
        drive(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        sb.push_back(mk(4'b0111, 4'b0000, 1'b0, 1'b0));
        @(negedge clk);
        o = sample_a(); e = sb.pop_front(); n_chk++;
        if (o !== e) begin n_fail++;
            $display("FAIL reset_state: got %b want %b", o, e); end
        n_chk++;
        if (ifa.stall_cnt_o !== 4'd0 || ifb.stall_cnt_o !== 32'd0) begin n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", ifa.stall_cnt_o, ifb.stall_cnt_o); end
        drive(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.push_back(mk(4'b0000, 4'b0111, 1'b1, 1'b0));
        #1;
        o = sample_a(); e = sb.pop_front(); n_chk++;
        if (o !== e) begin n_fail++;
            $display("FAIL reset_comb_kill: got %b want %b", o, e); end
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stall_map();
        logic [3:0] req[6] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0000, 4'b1111};
        logic [3:0] exp[6] = '{4'b0111, 4'b0111, 4'b0001, 4'b0011, 4'b0000, 4'b0111};
        obs_t o, e;
        for (int i = 0; i < 6; i++) begin
            drive(req[i], 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            sb.push_back(mk(exp[i], 4'b0000, 1'b0, 1'b0));
            @(negedge clk);
            o = sample_a(); e = sb.pop_front(); n_chk++;
            if (o !== e) begin n_fail++;
                $display("FAIL stall_map req=%b: got %b want %b", req[i], o, e); end
            tick();
        end
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_kill_window();
        logic [3:0] ek[4] = '{4'b0111, 4'b0110, 4'b0100, 4'b0000};
        obs_t o, e;
        for (int i = 0; i < 4; i++) begin
            drive(4'b0000, 4'b0000, i == 0, 1'b0, 1'b0, 1'b0, 1'b0);
            sb.push_back(mk(4'b0000, ek[i], i < 3, 1'b0));
            @(negedge clk);
            o = sample_a(); e = sb.pop_front(); n_chk++;
            if (o !== e) begin n_fail++;
                $display("FAIL kill_window cyc%0d: got %b want %b", i, o, e); end
            tick();
        end
    endtask

    task automatic test_stall_hold();
        logic [3:0] req[7] = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] es[7]  = '{4'b0000, 4'b0111, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] ek[7]  = '{4'b0111, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0000};
        obs_t o, e;
        for (int i = 0; i < 7; i++) begin
            drive(req[i], 4'b0000, i == 0, 1'b0, 1'b0, 1'b0, 1'b0);
            sb.push_back(mk(es[i], ek[i], i < 6, 1'b0));
            @(negedge clk);
            o = sample_a(); e = sb.pop_front(); n_chk++;
            if (o !== e) begin n_fail++;
                $display("FAIL stall_hold cyc%0d: got %b want %b", i, o, e); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic       br[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       tr[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] ek[6] = '{4'b0111, 4'b0111, 4'b0111, 4'b0110, 4'b0100, 4'b0000};
        obs_t o, e;
        for (int i = 0; i < 6; i++) begin
            drive(4'b0000, 4'b0000, br[i], tr[i], 1'b0, 1'b0, 1'b0);
            sb.push_back(mk(4'b0000, ek[i], i < 5, 1'b0));
            @(negedge clk);
            o = sample_a(); e = sb.pop_front(); n_chk++;
            if (o !== e) begin n_fail++;
                $display("FAIL back_to_back cyc%0d: got %b want %b", i, o, e); end
            tick();
        end
    endtask

    task automatic test_debug();
        logic [3:0] vld[16] = '{4'b1100, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic       hr[16]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       rs[16]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] es[16]  = '{4'b0000, 4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b0000};
        logic [3:0] ek[16]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0111, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic       eh[16]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        obs_t o, e;
        for (int i = 0; i < 16; i++) begin
            drive(4'b0000, vld[i], i == 9, 1'b0, hr[i], rs[i], 1'b0);
            sb.push_back(mk(es[i], ek[i], (i >= 9 && i <= 11), eh[i]));
            @(negedge clk);
            o = sample_a(); e = sb.pop_front(); n_chk++;
            if (o !== e) begin n_fail++;
                $display("FAIL debug cyc%0d: got %b want %b", i, o, e); end
            n_chk++;
            if (ifb.dbg_halted_o !== 1'b0 || ifb.stall_o !== 4'b0000) begin n_fail++;
                $display("FAIL nodebug cyc%0d: got halted=%b stall=%b want 0/0000",
                         i, ifb.dbg_halted_o, ifb.stall_o); end
            tick();
        end
    endtask

    task automatic test_stall_cnt();
        logic [31:0] ea, eb;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 23; i++) begin
            drive((i < 20) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cq.push_back((i < 15) ? i : 15);
            cq.push_back((i < 20) ? i : 20);
            @(negedge clk);
            ea = cq.pop_front(); eb = cq.pop_front(); n_chk++;
            if (32'(ifa.stall_cnt_o) !== ea || ifb.stall_cnt_o !== eb) begin n_fail++;
                $display("FAIL stall_cnt cyc%0d: got %0d/%0d want %0d/%0d",
                         i, ifa.stall_cnt_o, ifb.stall_cnt_o, ea, eb); end
            tick();
        end
        drive(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cq.push_back(0);
        @(negedge clk);
        ea = cq.pop_front(); n_chk++;
        if (32'(ifa.stall_cnt_o) !== ea || ifb.stall_cnt_o !== ea) begin n_fail++;
            $display("FAIL stall_cnt_clr: got %0d/%0d want %0d", ifa.stall_cnt_o, ifb.stall_cnt_o, ea); end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        obs_t o, e;
        drive(4'b0000, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 4'b1100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        sb.push_back(mk(4'b0011, 4'b0110, 1'b1, 1'b0));
        @(negedge clk);
        o = sample_a(); e = sb.pop_front(); n_chk++;
        if (o !== e) begin n_fail++;
            $display("FAIL mid_drain_pre: got %b want %b", o, e); end
        #1 rst_n = 1'b0;
        drive(4'b0000, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0));
        #1;
        o = sample_a(); e = sb.pop_front(); n_chk++;
        if (o !== e || ifa.stall_cnt_o !== 4'd0) begin n_fail++;
            $display("FAIL mid_drain_reset: got %b cnt=%0d want %b cnt=0", o, ifa.stall_cnt_o, e); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0));
            @(negedge clk);
            o = sample_a(); e = sb.pop_front(); n_chk++;
            if (o !== e) begin n_fail++;
                $display("FAIL post_reset_run cyc%0d: got %b want %b", i, o, e); end
            tick();
        end
    endtask

    initial begin
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_stall_map();
        test_kill_window();
        test_stall_hold();
        test_back_to_back();
        test_debug();
        test_stall_cnt();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
